// File: rtl/amiga_kbd_pkg.sv
// Shared types and wire codes for the Amiga keyboard transmitter.
// Also holds the helper that maps transmit slot to key-byte bit.
package amiga_kbd_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_BIT_SETUP,
        ST_BIT_CLKLO,
        ST_BIT_CLKHI,
        ST_WAIT_HS,
        ST_HS_END,
        ST_RS_CLKLO,
        ST_RS_CLKHI
    } kbd_state_e;

    typedef enum logic [1:0] {
        SRC_KEY,
        SRC_PWR_FD,
        SRC_PWR_FE,
        SRC_SYNC_F9
    } kbd_src_e;

    localparam logic [7:0] KBD_CODE_INIT     = 8'hFD;
    localparam logic [7:0] KBD_CODE_TERM     = 8'hFE;
    localparam logic [7:0] KBD_CODE_LOSTSYNC = 8'hF9;

    // The wire carries bits 6..0 first and the key-up flag (bit 7) last.
    function automatic logic [2:0] wire_bit_sel(input logic [2:0] slot);
        return (slot == 3'd7) ? 3'd7 : (3'd6 - slot);
    endfunction

endpackage

// File: rtl/amiga_kbd_tx_if.sv
// Key-event handshake between the HID decoder (master) and the keyboard
// transmitter (slave).
interface amiga_kbd_tx_if;
    logic       keystrobe;
    logic [7:0] keydat;
    logic       keyack;
    logic       busy;

    modport master (output keystrobe, output keydat, input keyack, input busy);
    modport slave  (input keystrobe, input keydat, output keyack, output busy);
endinterface

// File: rtl/amiga_kbd_hs_detect.sv
// KDAT synchroniser plus low-pulse filter: hs_seen once the line has been low
// long enough to count as a CIA handshake, hs_done when it is released again.
module amiga_kbd_hs_detect #(
    parameter int HS_MIN_CYC = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic kdat_in,
    input  logic clr,
    output logic hs_seen,
    output logic hs_done
);
    localparam int LW = $clog2(HS_MIN_CYC + 1);

    logic [1:0]    sync;
    logic [LW-1:0] lo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync   <= 2'b11;
            lo_cnt <= '0;
        end else begin
            sync <= {sync[0], kdat_in};
            if (clr || sync[1]) begin
                lo_cnt <= '0;
            end else if (lo_cnt != LW'(HS_MIN_CYC)) begin
                lo_cnt <= lo_cnt + 1'b1;
            end
        end
    end

    assign hs_seen = (lo_cnt == LW'(HS_MIN_CYC));
    // lo_cnt still holds its saturated value in the first cycle the line reads high.
    assign hs_done = hs_seen & sync[1];

endmodule

// File: rtl/amiga_kbd_tx.sv
// Amiga keyboard serialiser: power-up stream, key bytes, CIA handshake wait
// and lost-sync recovery on the open-drain KCLK/KDAT lines.
//
// state       | meaning
// PWRUP       | load $FD as the first byte after reset
// IDLE        | waiting for a pending key byte
// BIT_SETUP   | KDAT driven with the current bit
// BIT_CLKLO   | KCLK pulled low
// BIT_CLKHI   | KCLK released
// WAIT_HS     | lines released, waiting for the CIA to pull KDAT low
// HS_END      | handshake seen, waiting for KDAT to return high
// RS_CLKLO    | resync clock pulse, KCLK low
// RS_CLKHI    | resync clock pulse, KCLK released
module amiga_kbd_tx
    import amiga_kbd_pkg::*;
#(
    parameter int PHASE_CYC    = 142,
    parameter int HS_MIN_CYC   = 7,
    parameter int TIMEOUT_CYC  = 1014412,
    parameter bit SEND_POWERUP = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    amiga_kbd_tx_if.slave  key,
    input  logic           kdat_in,
    output logic           kdat_oe,
    output logic           kclk_oe
);
    localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

    kbd_state_e    state;
    kbd_src_e      src, held_src;
    logic [7:0]    tx_byte, held_byte, pend_byte;
    logic          pend_full, resync, keyack_r, busy_r;
    logic [2:0]    bit_idx;
    logic [PW-1:0] ph_cnt;
    logic [19:0]   to_cnt;
    logic          ph_done, hs_clr, hs_seen, hs_done;

    assign ph_done = (ph_cnt == PW'(PHASE_CYC - 1));
    assign hs_clr  = !((state == ST_WAIT_HS) || (state == ST_HS_END));

    amiga_kbd_hs_detect #(.HS_MIN_CYC(HS_MIN_CYC)) u_hs (
        .clk     (clk),
        .reset   (reset),
        .kdat_in (kdat_in),
        .clr     (hs_clr),
        .hs_seen (hs_seen),
        .hs_done (hs_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEND_POWERUP ? ST_PWRUP : ST_IDLE;
            src       <= SRC_KEY;
            held_src  <= SRC_KEY;
            tx_byte   <= '0;
            held_byte <= '0;
            pend_byte <= '0;
            pend_full <= 1'b0;
            resync    <= 1'b0;
            bit_idx   <= '0;
            ph_cnt    <= '0;
            to_cnt    <= '0;
            kdat_oe   <= 1'b0;
            kclk_oe   <= 1'b0;
            keyack_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            ph_cnt   <= ph_cnt + 1'b1;
            to_cnt   <= to_cnt + 1'b1;
            keyack_r <= 1'b0;
            busy_r   <= (state != ST_IDLE) || pend_full;
            case (state)
                ST_PWRUP: begin
                    tx_byte   <= KBD_CODE_INIT;
                    held_byte <= KBD_CODE_INIT;
                    src       <= SRC_PWR_FD;
                    held_src  <= SRC_PWR_FD;
                    bit_idx   <= '0;
                    kdat_oe   <= KBD_CODE_INIT[6];
                    state     <= ST_BIT_SETUP;
                    ph_cnt    <= '0;
                end
                ST_IDLE: if (pend_full) begin
                    pend_full <= 1'b0;
                    tx_byte   <= pend_byte;
                    held_byte <= pend_byte;
                    src       <= SRC_KEY;
                    held_src  <= SRC_KEY;
                    bit_idx   <= '0;
                    kdat_oe   <= pend_byte[6];
                    state     <= ST_BIT_SETUP;
                    ph_cnt    <= '0;
                end
                ST_BIT_SETUP: if (ph_done) begin
                    kclk_oe <= 1'b1;
                    state   <= ST_BIT_CLKLO;
                    ph_cnt  <= '0;
                end
                ST_BIT_CLKLO: if (ph_done) begin
                    kclk_oe <= 1'b0;
                    state   <= ST_BIT_CLKHI;
                    ph_cnt  <= '0;
                end
                ST_BIT_CLKHI: if (ph_done) begin
                    ph_cnt <= '0;
                    if (bit_idx == 3'd7) begin
                        kdat_oe <= 1'b0;
                        to_cnt  <= '0;
                        state   <= ST_WAIT_HS;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        kdat_oe <= tx_byte[wire_bit_sel(bit_idx + 3'd1)];
                        state   <= ST_BIT_SETUP;
                    end
                end
                ST_WAIT_HS: begin
                    if (hs_seen) begin
                        state  <= ST_HS_END;
                        ph_cnt <= '0;
                    end else if (to_cnt == 20'(TIMEOUT_CYC - 1)) begin
                        kclk_oe <= 1'b1;
                        resync  <= 1'b1;
                        state   <= ST_RS_CLKLO;
                        ph_cnt  <= '0;
                    end
                end
                ST_HS_END: if (hs_done) begin
                    ph_cnt  <= '0;
                    bit_idx <= '0;
                    if (resync) begin
                        // held_byte/held_src keep the interrupted byte for after $F9.
                        resync  <= 1'b0;
                        tx_byte <= KBD_CODE_LOSTSYNC;
                        src     <= SRC_SYNC_F9;
                        kdat_oe <= KBD_CODE_LOSTSYNC[6];
                        state   <= ST_BIT_SETUP;
                    end else begin
                        case (src)
                            SRC_KEY: begin
                                keyack_r <= 1'b1;
                                state    <= ST_IDLE;
                            end
                            SRC_PWR_FE: state <= ST_IDLE;
                            SRC_PWR_FD: begin
                                tx_byte   <= KBD_CODE_TERM;
                                held_byte <= KBD_CODE_TERM;
                                src       <= SRC_PWR_FE;
                                held_src  <= SRC_PWR_FE;
                                kdat_oe   <= KBD_CODE_TERM[6];
                                state     <= ST_BIT_SETUP;
                            end
                            SRC_SYNC_F9: begin
                                tx_byte <= held_byte;
                                src     <= held_src;
                                kdat_oe <= held_byte[6];
                                state   <= ST_BIT_SETUP;
                            end
                        endcase
                    end
                end
                ST_RS_CLKLO: if (ph_done) begin
                    kclk_oe <= 1'b0;
                    state   <= ST_RS_CLKHI;
                    ph_cnt  <= '0;
                end
                ST_RS_CLKHI: if (ph_done) begin
                    to_cnt <= '0;
                    state  <= ST_WAIT_HS;
                    ph_cnt <= '0;
                end
                default: state <= ST_IDLE;
            endcase
            if (key.keystrobe && !pend_full) begin
                pend_byte <= key.keydat;
                pend_full <= 1'b1;
            end
        end
    end

    assign key.keyack = keyack_r;
    assign key.busy   = busy_r;

endmodule

// File: tb/tb_amiga_kbd_tx.sv
// Self-checking bench: a CIA-side wire model decodes KCLK/KDAT frames and
// answers with handshakes, tests compare against spec-derived wire patterns.
module tb_amiga_kbd_tx;
    localparam int P   = 4;
    localparam int T   = 200;
    localparam int HSM = 7;
    localparam int RS_PERIOD = T + 2 * P;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic kdat_in, kdat_oe, kclk_oe;
    logic cia_low = 1'b0;

    amiga_kbd_tx_if kif();

    assign kdat_in = ~(kdat_oe | cia_low);

    amiga_kbd_tx #(
        .PHASE_CYC(P), .HS_MIN_CYC(HSM), .TIMEOUT_CYC(T), .SEND_POWERUP(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .key(kif),
        .kdat_in(kdat_in), .kdat_oe(kdat_oe), .kclk_oe(kclk_oe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         cyc = 0;
    int         nbits = 0;
    logic [7:0] cur = '0;
    logic [7:0] rx[$];
    int         rs_times[$];
    int         rs_bad = 0;
    int         frame_end_cyc = 0;
    bit         auto_hs = 1'b1;
    bit         hs_req = 1'b0;
    bit         glitch_req = 1'b0;
    int         hs_timer = 0, low_left = 0, glitch_left = 0;
    int         ack_count = 0, ack_cyc = 0, rel_cyc = 0;
    logic       prev_kclk = 1'b0;

    // Expected wire pattern: element i is the i-th KDAT drive value sent.
    function automatic logic [7:0] wire_of(input logic [7:0] v);
        logic [7:0] w;
        for (int i = 0; i < 7; i++) w[i] = v[6 - i];
        w[7] = v[7];
        return w;
    endfunction

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx.size()) return rx[i];
        return 8'hxx;
    endfunction

    // CIA-side model: frames are 8 KCLK pulses; pulses after a full frame with no
    // handshake given are resync pulses.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (kif.keyack === 1'b1) begin
                ack_count++;
                ack_cyc = cyc;
            end
            if (reset) begin
                nbits = 0; cia_low = 1'b0; hs_timer = 0; low_left = 0;
                glitch_left = 0; hs_req = 1'b0; glitch_req = 1'b0; prev_kclk = 1'b0;
            end else begin
                if (kclk_oe && !prev_kclk) begin
                    if (nbits < 8) begin
                        cur[nbits] = kdat_oe;
                        nbits++;
                        if (nbits == 8) begin
                            rx.push_back(cur);
                            frame_end_cyc = cyc;
                            if (auto_hs) hs_timer = 3 * P + 6;
                        end
                    end else begin
                        rs_times.push_back(cyc);
                        if (kdat_oe !== 1'b0) rs_bad++;
                    end
                end
                prev_kclk = kclk_oe;
                if (hs_req) begin
                    hs_req = 1'b0;
                    hs_timer = 1;
                end
                if (glitch_req) begin
                    glitch_req = 1'b0;
                    cia_low = 1'b1;
                    glitch_left = 3;
                end else if (glitch_left > 0) begin
                    glitch_left--;
                    if (glitch_left == 0) cia_low = 1'b0;
                end
                if (hs_timer > 0) begin
                    hs_timer--;
                    if (hs_timer == 0) begin
                        cia_low = 1'b1;
                        low_left = 10;
                    end
                end else if (low_left > 0) begin
                    low_left--;
                    if (low_left == 0) begin
                        cia_low = 1'b0;
                        nbits = 0;
                        rel_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic drive_strobe(input logic [7:0] v);
        @(posedge clk); #1;
        kif.keystrobe = 1'b1;
        kif.keydat = v;
        @(posedge clk); #1;
        kif.keystrobe = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && kif.busy !== 1'b0; i++) @(negedge clk);
        total++;
        if (kif.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_fall got=%b want=0", name, kif.busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (kclk_oe !== 1'b0) begin bad++; $display("FAIL reset_kclk got=%b want=0", kclk_oe); end
        total++; if (kdat_oe !== 1'b0) begin bad++; $display("FAIL reset_kdat got=%b want=0", kdat_oe); end
        total++; if (kif.keyack !== 1'b0) begin bad++; $display("FAIL reset_keyack got=%b want=0", kif.keyack); end
        total++; if (kif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", kif.busy); end
        rx.delete();
        auto_hs = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 1000 && rx.size() < 2; i++) @(negedge clk);
        total++; if (rx.size() < 2) begin bad++; $display("FAIL pwrup_frames got=%0d want=2", rx.size()); end
        total++; if (rx_at(0) !== wire_of(8'hFD)) begin bad++; $display("FAIL pwrup_fd got=%h want=%h", rx_at(0), wire_of(8'hFD)); end
        total++; if (rx_at(1) !== wire_of(8'hFE)) begin bad++; $display("FAIL pwrup_fe got=%h want=%h", rx_at(1), wire_of(8'hFE)); end
        wait_idle("pwrup");
        total++; if (ack_count !== 0) begin bad++; $display("FAIL pwrup_no_ack got=%0d want=0", ack_count); end
        total++; if (rx.size() !== 2) begin bad++; $display("FAIL pwrup_count got=%0d want=2", rx.size()); end
    endtask

    task automatic test_key_basic();
        int base = ack_count;
        rx.delete(); rs_times.delete();
        drive_strobe(8'h45);
        for (int i = 0; i < 600 && ack_count == base; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        // Spec sequence 1,0,0,0,1,0,1,0 packed with the first bit in bit 0.
        total++; if (rx_at(0) !== 8'h51) begin bad++; $display("FAIL key45_wire got=%h want=51", rx_at(0)); end
        total++; if (rx.size() !== 1) begin bad++; $display("FAIL key45_frames got=%0d want=1", rx.size()); end
        total++; if (rs_times.size() !== 0) begin bad++; $display("FAIL key45_extra_pulses got=%0d want=0", rs_times.size()); end
        total++; if (ack_count !== base + 1) begin bad++; $display("FAIL key45_ack_count got=%0d want=%0d", ack_count, base + 1); end
        total++; if (ack_cyc <= rel_cyc) begin bad++; $display("FAIL key45_ack_after_release got=%0d want>%0d", ack_cyc, rel_cyc); end
        wait_idle("key45");
    endtask

    task automatic test_random_keys();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] v = 8'($urandom_range(0, 255));
            int base = ack_count;
            rx.delete();
            drive_strobe(v);
            for (int i = 0; i < 600 && ack_count == base; i++) @(negedge clk);
            repeat (5) @(negedge clk);
            total++; if (rx_at(0) !== wire_of(v)) begin bad++; $display("FAIL rand_wire key=%h got=%h want=%h", v, rx_at(0), wire_of(v)); end
            total++; if (ack_count !== base + 1) begin bad++; $display("FAIL rand_ack key=%h got=%0d want=%0d", v, ack_count, base + 1); end
            wait_idle("rand");
        end
    endtask

    task automatic test_strobe_during_powerup();
        logic [7:0] v = 8'($urandom_range(0, 127));
        int base;
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        rx.delete();
        base = ack_count;
        #1 reset = 1'b0;
        for (int i = 0; i < 300 && nbits < 2; i++) @(negedge clk);
        drive_strobe(v);
        for (int i = 0; i < 1500 && (rx.size() < 3 || ack_count == base); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        total++; if (rx_at(0) !== wire_of(8'hFD)) begin bad++; $display("FAIL pend_fd got=%h want=%h", rx_at(0), wire_of(8'hFD)); end
        total++; if (rx_at(1) !== wire_of(8'hFE)) begin bad++; $display("FAIL pend_fe got=%h want=%h", rx_at(1), wire_of(8'hFE)); end
        total++; if (rx_at(2) !== wire_of(v)) begin bad++; $display("FAIL pend_key got=%h want=%h", rx_at(2), wire_of(v)); end
        total++; if (ack_count !== base + 1) begin bad++; $display("FAIL pend_ack got=%0d want=%0d", ack_count, base + 1); end
        wait_idle("pend");
    endtask

    task automatic test_resync();
        int base = ack_count;
        int n;
        auto_hs = 1'b0;
        rx.delete(); rs_times.delete(); rs_bad = 0;
        drive_strobe(8'h45);
        for (int i = 0; i < 1500 && rs_times.size() < 3; i++) @(negedge clk);
        total++; if (rs_times.size() < 3) begin bad++; $display("FAIL rs_pulses got=%0d want>=3", rs_times.size()); end
        if (rs_times.size() >= 3) begin
            total++; if (rs_times[0] - frame_end_cyc != RS_PERIOD) begin bad++; $display("FAIL rs_first got=%0d want=%0d", rs_times[0] - frame_end_cyc, RS_PERIOD); end
            total++; if (rs_times[1] - rs_times[0] != RS_PERIOD) begin bad++; $display("FAIL rs_period1 got=%0d want=%0d", rs_times[1] - rs_times[0], RS_PERIOD); end
            total++; if (rs_times[2] - rs_times[1] != RS_PERIOD) begin bad++; $display("FAIL rs_period2 got=%0d want=%0d", rs_times[2] - rs_times[1], RS_PERIOD); end
        end
        total++; if (rs_bad !== 0) begin bad++; $display("FAIL rs_kdat_released got=%0d want=0", rs_bad); end
        total++; if (ack_count !== base) begin bad++; $display("FAIL rs_no_ack got=%0d want=%0d", ack_count, base); end
        n = rs_times.size();
        for (int i = 0; i < 400 && rs_times.size() == n; i++) @(negedge clk);
        repeat (2 * P + 4) @(negedge clk);
        auto_hs = 1'b1;
        hs_req = 1'b1;
        for (int i = 0; i < 1500 && (rx.size() < 3 || ack_count == base); i++) @(negedge clk);
        wait_idle("rs");
        repeat (50) @(negedge clk);
        total++; if (rx_at(1) !== wire_of(8'hF9)) begin bad++; $display("FAIL rs_f9 got=%h want=%h", rx_at(1), wire_of(8'hF9)); end
        total++; if (rx_at(2) !== 8'h51) begin bad++; $display("FAIL rs_retx got=%h want=51", rx_at(2)); end
        total++; if (ack_count !== base + 1) begin bad++; $display("FAIL rs_one_ack got=%0d want=%0d", ack_count, base + 1); end
        total++; if (ack_cyc <= frame_end_cyc) begin bad++; $display("FAIL rs_ack_order got=%0d want>%0d", ack_cyc, frame_end_cyc); end
    endtask

    task automatic test_glitch();
        logic [7:0] v = 8'($urandom_range(0, 255));
        int base = ack_count;
        auto_hs = 1'b0;
        rx.delete(); rs_times.delete();
        drive_strobe(v);
        for (int i = 0; i < 400 && rx.size() < 1; i++) @(negedge clk);
        repeat (2 * P + 20) @(negedge clk);
        glitch_req = 1'b1;
        for (int i = 0; i < 400 && rs_times.size() < 1; i++) @(negedge clk);
        total++; if (rs_times.size() < 1) begin bad++; $display("FAIL glitch_timeout_pulse got=%0d want>=1", rs_times.size()); end
        if (rs_times.size() >= 1) begin
            total++; if (rs_times[0] - frame_end_cyc != RS_PERIOD) begin bad++; $display("FAIL glitch_timing got=%0d want=%0d", rs_times[0] - frame_end_cyc, RS_PERIOD); end
        end
        total++; if (ack_count !== base) begin bad++; $display("FAIL glitch_no_ack got=%0d want=%0d", ack_count, base); end
        repeat (2 * P + 4) @(negedge clk);
        auto_hs = 1'b1;
        hs_req = 1'b1;
        for (int i = 0; i < 1500 && (rx.size() < 3 || ack_count == base); i++) @(negedge clk);
        wait_idle("glitch");
        total++; if (rx_at(1) !== wire_of(8'hF9)) begin bad++; $display("FAIL glitch_f9 got=%h want=%h", rx_at(1), wire_of(8'hF9)); end
        total++; if (rx_at(2) !== wire_of(v)) begin bad++; $display("FAIL glitch_retx got=%h want=%h", rx_at(2), wire_of(v)); end
        total++; if (ack_count !== base + 1) begin bad++; $display("FAIL glitch_ack got=%0d want=%0d", ack_count, base + 1); end
    endtask

    task automatic test_reset_mid_bit();
        logic [7:0] v = 8'($urandom_range(0, 255));
        int base;
        auto_hs = 1'b1;
        rx.delete();
        drive_strobe(v);
        for (int i = 0; i < 400 && nbits < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        total++; if (kclk_oe !== 1'b1) begin bad++; $display("FAIL midbit_kclk_before got=%b want=1", kclk_oe); end
        reset = 1'b1;
        #1;
        total++; if (kclk_oe !== 1'b0) begin bad++; $display("FAIL midbit_kclk got=%b want=0", kclk_oe); end
        total++; if (kdat_oe !== 1'b0) begin bad++; $display("FAIL midbit_kdat got=%b want=0", kdat_oe); end
        total++; if (kif.keyack !== 1'b0) begin bad++; $display("FAIL midbit_keyack got=%b want=0", kif.keyack); end
        repeat (3) @(posedge clk);
        rx.delete();
        base = ack_count;
        #1 reset = 1'b0;
        for (int i = 0; i < 1000 && rx.size() < 2; i++) @(negedge clk);
        wait_idle("midbit");
        repeat (300) @(negedge clk);
        total++; if (rx_at(0) !== wire_of(8'hFD)) begin bad++; $display("FAIL midbit_fd got=%h want=%h", rx_at(0), wire_of(8'hFD)); end
        total++; if (rx_at(1) !== wire_of(8'hFE)) begin bad++; $display("FAIL midbit_fe got=%h want=%h", rx_at(1), wire_of(8'hFE)); end
        total++; if (rx.size() !== 2) begin bad++; $display("FAIL midbit_pending_dropped got=%0d want=2", rx.size()); end
        total++; if (ack_count !== base) begin bad++; $display("FAIL midbit_no_ack got=%0d want=%0d", ack_count, base); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        kif.keystrobe = 1'b0;
        kif.keydat = 8'h00;
        test_reset();
        test_key_basic();
        test_random_keys();
        test_strobe_during_powerup();
        test_resync();
        test_glitch();
        test_reset_mid_bit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
